// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble converter: unsigned binary in, eight packed BCD digits out.
// The result register only changes on a completion edge, so downstream displays never flicker.
module bin_to_bcd_display #(
  parameter int unsigned BIN_WIDTH = 27,
  parameter int unsigned MAX_VAL   = 99_999_999
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [31:0]          bcd_out,
  output logic                 done_out,
  output logic                 overflow_out
);

  localparam int unsigned OpW  = 27;
  localparam int unsigned CntW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  localparam logic StIdle    = 1'b0;
  localparam logic StConvert = 1'b1;

  logic                 state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [31:0]          scratch_q, scratch_d;
  logic [31:0]          scratch_adj;
  logic                 sat_q, sat_d;
  logic [31:0]          bcd_q, bcd_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  logic [OpW-1:0]       bin_ext;
  logic [OpW-1:0]       op_load;
  logic                 op_sat;
  logic                 last_iter;

  // Saturation is decided in the full 27-bit domain; the loaded value always fits BIN_WIDTH.
  always_comb begin
    bin_ext = OpW'(bin_in);
    op_sat  = bin_ext > OpW'(MAX_VAL);
    op_load = op_sat ? OpW'(MAX_VAL) : bin_ext;
  end

  assign last_iter = (cnt_q == CntW'(BIN_WIDTH - 1));

  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 8; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    sat_d     = sat_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          shift_d   = op_load[BIN_WIDTH-1:0];
          sat_d     = op_sat;
          scratch_d = 32'h0;
          cnt_d     = '0;
          state_d   = StConvert;
        end
      end
      StConvert: begin
        scratch_d = {scratch_adj[30:0], shift_q[BIN_WIDTH-1]};
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q + 1'b1;
        if (last_iter) begin
          bcd_d   = scratch_d;
          ovf_d   = sat_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= 32'h0;
      sat_q     <= 1'b0;
      bcd_q     <= 32'h0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      sat_q     <= sat_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ready_out    = (state_q == StIdle);
  assign bcd_out      = bcd_q;
  assign done_out     = done_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Directed bench for bin_to_bcd_display: a cycle-level behavioural model checked every cycle,
// plus literal expectations for each directed vector.
module tb_bin_to_bcd_display;

  localparam int unsigned BW  = 27;
  localparam int unsigned MAX = 99_999_999;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] bin = '0;
  logic          valid = 1'b0;
  logic          ready_out, done_out, overflow_out;
  logic [31:0]   bcd_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  bin_to_bcd_display #(.BIN_WIDTH(BW), .MAX_VAL(MAX)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .bin_in      (bin),
    .valid_in    (valid),
    .ready_out   (ready_out),
    .bcd_out     (bcd_out),
    .done_out    (done_out),
    .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    x = (v > MAX) ? MAX : v;
    r = 32'h0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model: a busy countdown from accept to completion, with the result computed arithmetically.
  int          m_busy = 0;
  logic [31:0] m_pend = 32'h0;
  logic        m_pend_ovf = 1'b0;
  logic [31:0] m_bcd = 32'h0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_done <= 1'b0;
    if (rst) begin
      m_busy <= 0;
      m_bcd  <= 32'h0;
      m_ovf  <= 1'b0;
    end else if (m_busy == 0) begin
      if (valid) begin
        m_busy     <= BW;
        m_pend     <= to_bcd(int'(bin));
        m_pend_ovf <= (int'(bin) > int'(MAX));
      end
    end else begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_bcd  <= m_pend;
        m_ovf  <= m_pend_ovf;
        m_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(ready_out), 32'(m_busy == 0));
      check("done", 32'(done_out), 32'(m_done));
      check("bcd", bcd_out, m_bcd);
      check("overflow", 32'(overflow_out), 32'(m_ovf));
    end
  end

  // One request; optional stray valid at iteration glitch_k, optional reset at iteration rst_k.
  task automatic run(input logic [BW-1:0] v, input logic [31:0] eb, input logic eo,
                     input int glitch_k, input int rst_k);
    int k;
    int pulses;
    bit seen;
    @(negedge clk);
    valid = 1'b1;
    bin = v;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    bin = ~v;
    check("ready_drop", 32'(ready_out), 32'h0);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      if (k == glitch_k) begin
        valid = 1'b1;
        bin = 42;
      end else if (k == glitch_k + 1) begin
        valid = 1'b0;
      end
      if (k == rst_k) rst = 1'b1;
      @(negedge clk);
      k++;
      if (rst) begin
        rst = 1'b0;
        check("rst_bcd", bcd_out, 32'h0);
        check("rst_done", 32'(done_out), 32'h0);
        check("rst_ready", 32'(ready_out), 32'h1);
        check("rst_ovf", 32'(overflow_out), 32'h0);
        pulses = 0;
        for (int i = 0; i < 35; i++) begin
          @(negedge clk);
          if (done_out) pulses++;
        end
        check("rst_no_done", 32'(pulses), 32'h0);
        return;
      end
      if (done_out) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'h1);
    check("latency", 32'(k), 32'(BW));
    check("result", bcd_out, eb);
    check("result_ovf", 32'(overflow_out), 32'(eo));
    check("model_pin", m_bcd, eb);
    @(negedge clk);
    check("done_once", 32'(done_out), 32'h0);
    check("idle_after", 32'(ready_out), 32'h1);
  endtask

  initial begin
    int t_done [3];
    logic [31:0] r_done [3];
    int nd;
    int guard;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_ready", 32'(ready_out), 32'h1);
    check("reset_bcd", bcd_out, 32'h0);
    check("reset_done", 32'(done_out), 32'h0);
    check("reset_ovf", 32'(overflow_out), 32'h0);

    run(27'd0,           32'h0000_0000, 1'b0, -1, -1);
    run(27'd12_345_678,  32'h1234_5678, 1'b0, -1, -1);
    run(27'd99_999_999,  32'h9999_9999, 1'b0, -1, -1);
    run(27'd134_217_727, 32'h9999_9999, 1'b1, -1, -1);
    run(27'd5,           32'h0000_0005, 1'b0, -1, -1);
    run(27'd1_000_000,   32'h0100_0000, 1'b0,  5, -1);
    run(27'd100_000_000, 32'h9999_9999, 1'b1, -1, -1);

    // valid held high: accepts back to back, bin stepped after each accept
    @(negedge clk);
    valid = 1'b1;
    bin = 27'd7;
    @(posedge clk);
    @(negedge clk);
    bin = 27'd80;
    nd = 0;
    guard = 0;
    while (nd < 3 && guard < 120) begin
      if (done_out) begin
        t_done[nd] = cyc;
        r_done[nd] = bcd_out;
        nd++;
        if (nd == 2) bin = 27'd909;
        if (nd == 3) valid = 1'b0;
      end
      if (nd < 3) @(negedge clk);
      guard++;
    end
    check("held_count", 32'(nd), 32'd3);
    if (nd == 3) begin
      check("held_r0", r_done[0], 32'h0000_0007);
      check("held_r1", r_done[1], 32'h0000_0080);
      check("held_r2", r_done[2], 32'h0000_0909);
      check("held_gap1", 32'(t_done[1] - t_done[0]), 32'd28);
      check("held_gap2", 32'(t_done[2] - t_done[1]), 32'd28);
    end
    repeat (2) @(negedge clk);

    run(27'd55_555_555, 32'h0, 1'b0, -1, 9);
    run(27'd314,        32'h0000_0314, 1'b0, -1, -1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
